prog_timer: RTL and testbench
=============================

# prog_timer

Parametrised programmable down-counting timer: a loaded period is counted down to zero on enabled ticks, with a one-cycle expire pulse. Supports one-shot and periodic (auto-reload) modes, start/stop control and an optional tick prescaler. It sits beside the control logic as the general timing source for timeouts and periodic events, replacing fixed-width free-running down-counters.

## Interface

Parameters:
- WIDTH, 8, counter and load-value width (≥2)
- PRESCALE, 4, en pulses per tick (≥1); used only when the prescaler is compiled in

Ports:
- clk  input  1  clock, all logic on the rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  tick enable; the timer advances only on cycles with a tick
- start  input  1  load load_val and start counting
- stop  input  1  halt counting and hold count
- periodic  input  1  0 = one-shot, 1 = auto-reload; sampled on each expiry
- load_val  input  WIDTH  period value; sampled on start and on periodic reload
- count  output  WIDTH  current counter value
- busy  output  1  high while in RUN
- expire  output  1  one-cycle pulse when a tick is applied with count == 0

## Operation

- States: IDLE, RUN. Reset: state IDLE, count = all ones ('1), busy 0, expire 0, prescaler count 0.
- IDLE: count holds. start → count <= load_val, state RUN. stop is ignored.
- RUN, on a tick:
  - count != 0 → count <= count - 1.
  - count == 0 → expire <= 1.
    - periodic=1: count <= load_val, stay in RUN.
    - periodic=0: count stays 0, state IDLE.
- RUN, no tick: count holds.
- RUN, stop=1 → state IDLE, count holds its value, no expire. A pending tick on the same cycle is discarded.
- RUN, start=1 (stop=0) → restart: count <= load_val, prescaler cleared, tick ignored, no expire.
- start and stop on the same cycle: stop wins in RUN; start wins in IDLE.
- load_val = 0: one-shot expires on the first tick. Periodic expires on every tick.
- Arithmetic is unsigned, modulo 2^WIDTH. count == 0 is never decremented, so no wrap-around occurs.
- rst has priority over all inputs in every state and clears mid-operation state fully.

## Timing

- Every output is a register; there are no combinational input-to-output paths.
- start at edge N → count = load_val and busy = 1 after edge N.
- Tick at edge M with count == 0 → expire high for exactly one cycle after edge M. In one-shot mode busy falls in that same cycle.
- One-shot with period L: expire follows the (L+1)-th tick after start.
- Periodic with period L: expire repeats every L+1 ticks.
- stop at edge S → busy = 0 after edge S.

## Configuration

- PROG_TIMER_PRESCALE_EN defined:
  - A prescaler counts en pulses; tick = en AND (prescaler count == PRESCALE-1).
  - The prescaler wraps to 0 on a tick and is cleared on start and on rst.
  - It advances only in RUN.
- Not defined: tick = en, and PRESCALE is unused.

## Structure

- Package timer_pkg holds:
  - typedef enum logic {IDLE, RUN} timer_state_t
  - typedef enum logic {ONE_SHOT, PERIODIC} timer_mode_t
- Sub-module tick_prescaler (parameter PRESCALE; ports clk, rst, clr, en, tick) is instantiated only under PROG_TIMER_PRESCALE_EN.

## Test plan

- Reset: hold rst 3 cycles, WIDTH=8 → count=8'hFF, busy=0, expire=0; then en=1 with no start → count stays 8'hFF.
- One-shot: load_val=3, periodic=0, en=1 constant, pulse start → count 3,2,1,0; expire pulses once on the 4th tick; busy=0 afterwards; count stays 0.
- Periodic: load_val=2, periodic=1, en=1 → expire every 3 cycles for 10 periods; count sequence 2,1,0,2,1,0…
- Stop/restart: load_val=10, stop when count=6 → busy=0, count holds 6 for 5 cycles. Then start with load_val=4 → count=4, and counting resumes.
- Simultaneous events:
  - start+stop in RUN → IDLE, count held.
  - start+stop in IDLE → RUN with load_val.
  - rst during RUN with count=5 → count=8'hFF, busy=0, no expire.
- Prescaler (macro defined, PRESCALE=4, en=1, load_val=1, one-shot) → expire 8 cycles after start.
- Prescaler, sparse en: en every other cycle → expire 16 cycles after start.
- Prescaler, no macro: same one-shot stimulus → expire 2 cycles after start.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types for the programmable down-counting timer.
package timer_pkg;

   typedef enum logic {IDLE, RUN} timer_state_t;

   typedef enum logic {ONE_SHOT, PERIODIC} timer_mode_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides en pulses by PRESCALE; tick marks the last en pulse of each group.
module tick_prescaler #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_cnt;

   assign tick = en && (pre_cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pre_cnt <= '0;
      end else if (en) begin
         pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + PW'(1);
      end
   end

endmodule

// File: rtl/prog_timer.sv
// Programmable down-counting timer with one-shot / auto-reload modes.
// Define PROG_TIMER_PRESCALE_EN to divide en by PRESCALE before it ticks the counter.
module prog_timer
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic             stop,
   input  logic             periodic,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             expire
);

   if (WIDTH < 2 || PRESCALE < 1) begin : g_bad_param
      $error("prog_timer: WIDTH must be >= 2 and PRESCALE >= 1");
   end

   timer_state_t     state, state_nxt;
   logic [WIDTH-1:0] count_q, count_nxt;
   logic             expire_q, expire_nxt;
   logic             tick_c;
   timer_mode_t      mode_c;

`ifdef PROG_TIMER_PRESCALE_EN
   // Prescaler only advances while counting; a stop cycle discards its en pulse.
   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (start),
      .en   (en && (state == RUN) && !stop),
      .tick (tick_c)
   );
`else
   assign tick_c = en;
`endif

   assign mode_c = timer_mode_t'(periodic);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count_q  <= '1;
         expire_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         count_q  <= count_nxt;
         expire_q <= expire_nxt;
      end
   end

   // Next state: stop beats start in RUN, start beats stop in IDLE.
   always_comb begin
      state_nxt  = state;
      count_nxt  = count_q;
      expire_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               count_nxt = load_val;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (start) begin
               count_nxt = load_val;
            end else if (tick_c) begin
               if (count_q != '0) begin
                  count_nxt = count_q - WIDTH'(1);
               end else begin
                  expire_nxt = 1'b1;
                  if (mode_c == PERIODIC) begin
                     count_nxt = load_val;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign count  = count_q;
   assign busy   = (state == RUN);
   assign expire = expire_q;

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: driver pushes model expectations, monitor compares.
module tb_prog_timer;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned PRESCALE = 4;

   logic             clk = 1'b1;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             periodic = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             expire;

   prog_timer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .start    (start),
      .stop     (stop),
      .periodic (periodic),
      .load_val (load_val),
      .count    (count),
      .busy     (busy),
      .expire   (expire)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cnt;
      bit          run;
      bit          exp;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   bit   done = 0;

   // Reference model state, plain integers
   int unsigned m_cnt = 255;
   bit          m_run = 0;
   bit          m_exp = 0;
   int unsigned m_pre = 0;

`ifdef PROG_TIMER_PRESCALE_EN
   localparam bit HAS_PRE = 1'b1;
`else
   localparam bit HAS_PRE = 1'b0;
`endif

   task automatic model_step(input bit r, input bit e, input bit s, input bit p,
                             input bit per, input int unsigned lv);
      bit tk;
      if (r) begin
         m_cnt = (1 << WIDTH) - 1;
         m_run = 0;
         m_exp = 0;
         m_pre = 0;
         return;
      end
      tk = e;
      if (HAS_PRE) begin
         tk = 0;
         if (s) m_pre = 0;
         else if (m_run && !p && e) begin
            if (m_pre == PRESCALE - 1) begin
               tk = 1;
               m_pre = 0;
            end else m_pre++;
         end
      end
      m_exp = 0;
      if (!m_run) begin
         if (s) begin
            m_cnt = lv;
            m_run = 1;
         end
      end else if (p) m_run = 0;
      else if (s) m_cnt = lv;
      else if (tk) begin
         if (m_cnt > 0) m_cnt--;
         else begin
            m_exp = 1;
            if (per) m_cnt = lv;
            else m_run = 0;
         end
      end
   endtask

   // Drive one cycle of inputs and queue the expected post-edge outputs
   task automatic cyc(input bit r, input bit e, input bit s, input bit p,
                      input bit per, input int unsigned lv);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; start = s; stop = p; periodic = per;
      load_val = WIDTH'(lv);
      model_step(r, e, s, p, per, lv);
      x.cnt = m_cnt; x.run = m_run; x.exp = m_exp;
      q.push_back(x);
   endtask

   task automatic check_const(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Count cycles from a start until expire, with en on every cycle or every other one
   task automatic measure(input bit sparse, input int req, input string name);
      int lat = -1;
      cyc(0, 1, 1, 0, 0, 1);
      for (int k = 1; k <= 40; k++) begin
         cyc(0, sparse ? ((k % 2) == 0) : 1'b1, 0, 0, 0, 1);
         @(posedge clk); #1;
         if (expire) begin
            lat = k;
            break;
         end
      end
      check_const(name, lat, req);
      repeat (2) cyc(0, 1, 0, 0, 0, 1);
   endtask

   // Monitor: every clock the DUT presents count/busy/expire
   initial begin
      exp_t x;
      forever begin
         @(posedge clk); #1;
         if (q.size() != 0) begin
            x = q.pop_front();
            checks += 3;
            if (count != WIDTH'(x.cnt)) begin
               errors++;
               $display("FAIL count @%0t: got %0d expected %0d", $time, count, x.cnt);
            end
            if (busy != x.run) begin
               errors++;
               $display("FAIL busy @%0t: got %0b expected %0b", $time, busy, x.run);
            end
            if (expire != x.exp) begin
               errors++;
               $display("FAIL expire @%0t: got %0b expected %0b", $time, expire, x.exp);
            end
         end
      end
   end

   initial begin
      int guard;
      // Reset, then en without start
      repeat (3) cyc(1, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check_const("reset_count", int'(count), 255);
      check_const("reset_busy", int'(busy), 0);
      repeat (5) cyc(0, 1, 0, 0, 0, 0);

      // One-shot, load 3
      cyc(0, 1, 1, 0, 0, 3);
      repeat (8 * (HAS_PRE ? PRESCALE : 1) + 4) cyc(0, 1, 0, 0, 0, 3);
      @(posedge clk); #1;
      check_const("oneshot_final_count", int'(count), 0);
      check_const("oneshot_final_busy", int'(busy), 0);

      // Periodic, load 2, ten periods
      cyc(0, 1, 1, 0, 1, 2);
      repeat (30 * (HAS_PRE ? PRESCALE : 1)) cyc(0, 1, 0, 0, 1, 2);

      // Stop at 6, hold, then restart at 4
      cyc(0, 1, 1, 0, 0, 10);
      guard = 0;
      while (m_cnt != 6 && guard < 200) begin
         cyc(0, 1, 0, 0, 0, 10);
         guard++;
      end
      check_const("reach_six_guard", int'(guard < 200), 1);
      cyc(0, 1, 0, 1, 0, 10);
      repeat (5) cyc(0, 1, 0, 0, 0, 10);
      @(posedge clk); #1;
      check_const("stop_hold_count", int'(count), 6);
      cyc(0, 1, 1, 0, 0, 4);
      repeat (6) cyc(0, 1, 0, 0, 0, 4);

      // start+stop in RUN then in IDLE
      cyc(0, 1, 1, 1, 0, 9);
      cyc(0, 1, 1, 1, 0, 7);
      repeat (3) cyc(0, 1, 0, 0, 0, 7);

      // rst mid-run with count 5
      cyc(0, 0, 1, 0, 0, 5);
      cyc(1, 1, 0, 0, 0, 5);
      @(posedge clk); #1;
      check_const("rst_run_count", int'(count), 255);
      cyc(0, 1, 0, 0, 0, 5);

      // load_val 0 in both modes
      cyc(0, 1, 1, 0, 1, 0);
      repeat (6) cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 1, 0, 1, 1, 0);
      cyc(0, 1, 1, 0, 0, 0);
      repeat (6) cyc(0, 1, 0, 0, 0, 0);

      // Expire latency for load_val 1
      measure(0, HAS_PRE ? 8 : 2, "latency_dense");
      measure(1, HAS_PRE ? 16 : 4, "latency_sparse");

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         int unsigned lv;
         lv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
             $urandom_range(0, 1), lv);
      end

      repeat (2) @(posedge clk);
      #2;
      check_const("queue_drained", q.size(), 0);
      done = 1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
